if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register, the instruction memory (loaded by the debug unit before run), and the IF/ID pipeline register.
- Drives the instruction and PC+4 consumed by the decode stage; accepts redirect, stall and flush requests from the later stages and the hazard unit.

Parameters:
- NB_PC, 32, PC width in bits.
- NB_INST, 32, instruction width in bits.
- MEM_DEPTH, 256, instruction memory depth in words.
- NB_ADDR, 8, word address width; equals log2(MEM_DEPTH).
- HALT_INST, 32'hFFFFFFFF, encoding that stops fetch.

Ports:
- i_IF_clock  in  1  single clock; all state updates on the rising edge.
- i_IF_reset  in  1  synchronous, active-high reset.
- i_IF_enable  in  1  run enable from the debug unit; 0 freezes all pipeline state.
- i_IF_stall  in  1  hazard unit request: hold the PC and the IF/ID register.
- i_IF_flush  in  1  load a NOP (32'h0) into IF/ID.
- i_IF_pc_src  in  1  taken branch; redirect to i_IF_branch_addr.
- i_IF_branch_addr  in  NB_PC  branch target.
- i_IF_jump  in  1  jump or jr/jalr from decode; redirect to i_IF_jump_addr.
- i_IF_jump_addr  in  NB_PC  jump target.
- i_IF_wr_en  in  1  program-load write strobe.
- i_IF_wr_addr  in  NB_ADDR  word address of the program-load write.
- i_IF_wr_data  in  NB_INST  program-load data.
- o_IF_inst  out  NB_INST  IF/ID instruction.
- o_IF_pc  out  NB_PC  IF/ID PC+4.
- o_IF_pc_current  out  NB_PC  live PC register, for debug readout.
- o_IF_halt  out  1  sticky halt flag.

Behaviour:
- **Reset.** Synchronous, highest priority. PC=0, o_IF_inst=0, o_IF_pc=0, o_IF_halt=0. Memory contents are not cleared.
- **Memory.** Synchronous write, asynchronous read.
  - Writes take effect only when i_IF_wr_en=1 and i_IF_enable=0; writes with enable=1 are ignored.
  - Read index = PC[NB_ADDR+1:2], so addresses wrap modulo MEM_DEPTH words.
  - A write and a fetch to the same word never coincide, because writes are only allowed while enable=0.
- **Advance condition.** Fetch advances when `adv = i_IF_enable & ~i_IF_stall & ~o_IF_halt`.
- **Next PC, highest priority first:** reset → 0; i_IF_pc_src → branch_addr; i_IF_jump → jump_addr; adv → PC+4; otherwise hold.
  - Branch beats jump: the branch belongs to the older instruction.
  - PC+4 wraps at 2^NB_PC.
  - Redirects are honoured whenever i_IF_enable=1, even during stall.
- **IF/ID register, highest priority first:** reset → 0; i_IF_flush (with enable=1) → inst=0, pc=PC+4; adv → inst=mem[PC], pc=PC+4; otherwise hold.
  - Flush beats stall.
  - Latency: the instruction at PC appears on o_IF_inst one clock after the edge that samples it.
- **Halt.**
  - When adv=1 and mem[PC]==HALT_INST: the IF/ID register loads HALT_INST, o_IF_halt=1, and the PC holds (does not increment).
  - While halted, the PC and IF/ID hold, except as below.
  - If i_IF_pc_src=1 while halted, the halt was fetched in a branch shadow: clear o_IF_halt and redirect the PC. Flush still applies as usual.
  - i_IF_jump alone does not clear halt.
- **Enable low.** i_IF_enable=0 freezes the PC, IF/ID and halt (memory writes are still allowed). Redirect, stall and flush are ignored.
- **Reset mid-run.** Returns to the reset state on the next edge; a pending halt clears; the memory program is retained.

Optional Feature:
- IF_MISALIGN_TRAP_EN.
- **Defined:**
  - Adds output o_IF_misalign (1 bit, reset 0).
  - A redirect target with bits [1:0]≠0 sets o_IF_misalign sticky and freezes fetch like halt, with the PC loaded with the target.
  - A later aligned i_IF_pc_src clears it; reset clears it.
- **Undefined:**
  - No port.
  - Target bits [1:0] are forced to 0 on load.

Test Plan:
- **Load and fetch.** Load 8 words, words 0..7 = 32'h00000000 + i·0x11. Release reset, enable=1. o_IF_inst sequence is 0x00, 0x11, 0x22, …; o_IF_pc sequence is 4, 8, 12, ….
- **Stall.** Assert stall for 2 cycles at PC=8. PC holds 8 and o_IF_inst holds word 1 for both cycles; fetch resumes with word 2.
- **Flush and redirect.** Assert flush + pc_src with branch_addr=0x14 at PC=0x8. Next cycle o_IF_inst=0 and PC=0x14; the following cycle o_IF_inst=word 5.
- **Simultaneous redirects.** pc_src and jump in the same cycle, branch_addr=0x20, jump_addr=0x40. PC becomes 0x20.
- **Halt.** Word 3 = 0xFFFFFFFF. After fetching it, o_IF_halt=1, PC stays 0xC, and o_IF_inst stays 0xFFFFFFFF for 10 cycles. Then pc_src with branch_addr=0x4 clears halt and fetches word 1.
- **Write guard and wrap.** A write with enable=1 leaves memory unchanged. jump_addr=0x3FC (word 255) with MEM_DEPTH=256: the next fetch is at PC=0x400 and reads word 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, program memory and IF/ID register.
// Build macro: IF_MISALIGN_TRAP_EN adds o_IF_misalign (misaligned redirect trap).
// Ports:
//   i_IF_clock, i_IF_reset (sync, active-high)
//   i_IF_enable, i_IF_stall, i_IF_flush: run / hazard controls
//   i_IF_pc_src + i_IF_branch_addr, i_IF_jump + i_IF_jump_addr: redirects
//   i_IF_wr_en/i_IF_wr_addr/i_IF_wr_data: program load (enable low only)
//   o_IF_inst, o_IF_pc: IF/ID instruction and PC+4
//   o_IF_pc_current: live PC; o_IF_halt: sticky halt flag
module if_stage #(
  parameter int NB_PC     = 32,
  parameter int NB_INST   = 32,
  parameter int MEM_DEPTH = 256,
  parameter int NB_ADDR   = 8,
  parameter logic [NB_INST-1:0] HALT_INST = 32'hFFFFFFFF
) (
  input  logic               i_IF_clock,
  input  logic               i_IF_reset,
  input  logic               i_IF_enable,
  input  logic               i_IF_stall,
  input  logic               i_IF_flush,
  input  logic               i_IF_pc_src,
  input  logic [NB_PC-1:0]   i_IF_branch_addr,
  input  logic               i_IF_jump,
  input  logic [NB_PC-1:0]   i_IF_jump_addr,
  input  logic               i_IF_wr_en,
  input  logic [NB_ADDR-1:0] i_IF_wr_addr,
  input  logic [NB_INST-1:0] i_IF_wr_data,
  output logic [NB_INST-1:0] o_IF_inst,
  output logic [NB_PC-1:0]   o_IF_pc,
  output logic [NB_PC-1:0]   o_IF_pc_current,
  output logic               o_IF_halt
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic               o_IF_misalign
`endif
);

  logic [NB_INST-1:0] mem [MEM_DEPTH];
  logic [NB_INST-1:0] fetch_inst;
  logic [NB_PC-1:0]   pc_plus4;
  logic [NB_PC-1:0]   br_tgt;
  logic [NB_PC-1:0]   jp_tgt;
  logic               fetch_halt;
  logic               frozen;
  logic               adv;

  // Word index wraps modulo MEM_DEPTH.
  assign fetch_inst = mem[o_IF_pc_current[NB_ADDR+1:2]];
  assign fetch_halt = (fetch_inst == HALT_INST);
  assign pc_plus4   = o_IF_pc_current + NB_PC'(4);

`ifdef IF_MISALIGN_TRAP_EN
  logic br_mis;
  logic jp_mis;

  assign br_tgt = i_IF_branch_addr;
  assign jp_tgt = i_IF_jump_addr;
  assign br_mis = |i_IF_branch_addr[1:0];
  assign jp_mis = |i_IF_jump_addr[1:0];
  assign frozen = o_IF_halt | o_IF_misalign;

  always_ff @(posedge i_IF_clock) begin
    if (i_IF_reset) begin
      o_IF_misalign <= 1'b0;
    end else if (i_IF_enable) begin
      if (i_IF_pc_src)
        o_IF_misalign <= br_mis;
      else if (i_IF_jump && jp_mis)
        o_IF_misalign <= 1'b1;
    end
  end
`else
  // Without the trap, redirect targets are word-aligned on load.
  assign br_tgt = i_IF_branch_addr & ~NB_PC'(3);
  assign jp_tgt = i_IF_jump_addr & ~NB_PC'(3);
  assign frozen = o_IF_halt;
`endif

  assign adv = i_IF_enable & ~i_IF_stall & ~frozen;

  // Program load only while the pipeline is stopped.
  always_ff @(posedge i_IF_clock) begin
    if (i_IF_wr_en && !i_IF_enable)
      mem[i_IF_wr_addr] <= i_IF_wr_data;
  end

  always_ff @(posedge i_IF_clock) begin
    if (i_IF_reset) begin
      o_IF_pc_current <= '0;
      o_IF_inst       <= '0;
      o_IF_pc         <= '0;
      o_IF_halt       <= 1'b0;
    end else if (i_IF_enable) begin
      // Branch is older than the jump, so it wins.
      if (i_IF_pc_src)
        o_IF_pc_current <= br_tgt;
      else if (i_IF_jump)
        o_IF_pc_current <= jp_tgt;
      else if (adv && !fetch_halt)
        o_IF_pc_current <= pc_plus4;

      if (i_IF_flush) begin
        o_IF_inst <= '0;
        o_IF_pc   <= pc_plus4;
      end else if (adv) begin
        o_IF_inst <= fetch_inst;
        o_IF_pc   <= pc_plus4;
      end

      // A taken branch means the halt sat in its shadow.
      if (i_IF_pc_src)
        o_IF_halt <= 1'b0;
      else if (adv && fetch_halt)
        o_IF_halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks for if_stage.
// Steps: reset, load, fetch, stall, flush, redirects, halt, wrap, reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, enable, stall, flush;
  logic        pc_src, jump, wr_en;
  logic [31:0] branch_addr, jump_addr, wr_data;
  logic [7:0]  wr_addr;
  logic [31:0] inst, pc, pc_cur;
  logic        halt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .i_IF_clock      (clk),
    .i_IF_reset      (reset),
    .i_IF_enable     (enable),
    .i_IF_stall      (stall),
    .i_IF_flush      (flush),
    .i_IF_pc_src     (pc_src),
    .i_IF_branch_addr(branch_addr),
    .i_IF_jump       (jump),
    .i_IF_jump_addr  (jump_addr),
    .i_IF_wr_en      (wr_en),
    .i_IF_wr_addr    (wr_addr),
    .i_IF_wr_data    (wr_data),
    .o_IF_inst       (inst),
    .o_IF_pc         (pc),
    .o_IF_pc_current (pc_cur),
    .o_IF_halt       (halt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic chk3(input string tag,
                      input logic [31:0] e_inst,
                      input logic [31:0] e_pc,
                      input logic [31:0] e_cur);
    chk({tag, ".inst"}, inst, e_inst);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".cur"}, pc_cur, e_cur);
  endtask

  initial begin
    reset = 1; enable = 0; stall = 0; flush = 0;
    pc_src = 0; jump = 0; wr_en = 0;
    branch_addr = 0; jump_addr = 0;
    wr_addr = 0; wr_data = 0;

    cyc();
    chk3("reset", 32'h0, 32'h0, 32'h0);
    chk("reset.halt", {31'b0, halt}, 32'h0);

    // Program load with the pipeline stopped.
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 8'(i); wr_data = 32'(i * 32'h11);
      cyc();
    end
    wr_addr = 8'd255; wr_data = 32'hA5A50001;
    cyc();

    // Write while enabled must be ignored; stall keeps PC at 0.
    enable = 1; stall = 1;
    wr_addr = 8'd2; wr_data = 32'hDEADBEEF;
    cyc();
    wr_en = 0;
    chk3("wguard", 32'h0, 32'h0, 32'h0);

    // Load and fetch.
    stall = 0;
    cyc(); chk3("fetch0", 32'h00, 32'h4, 32'h4);
    cyc(); chk3("fetch1", 32'h11, 32'h8, 32'h8);

    // Stall two cycles at PC=8.
    stall = 1;
    cyc(); chk3("stall0", 32'h11, 32'h8, 32'h8);
    cyc(); chk3("stall1", 32'h11, 32'h8, 32'h8);
    stall = 0;
    cyc(); chk3("resume", 32'h22, 32'hC, 32'hC);

    // Jump back to 8, then flush with a branch to 0x14.
    jump = 1; jump_addr = 32'h8;
    cyc(); chk3("jump8", 32'h33, 32'h10, 32'h8);
    jump = 0;
    flush = 1; pc_src = 1; branch_addr = 32'h14;
    cyc(); chk3("flush", 32'h0, 32'hC, 32'h14);
    flush = 0; pc_src = 0;
    cyc(); chk3("after_fl", 32'h55, 32'h18, 32'h18);

    // Branch beats jump.
    pc_src = 1; branch_addr = 32'h20;
    jump = 1; jump_addr = 32'h40;
    cyc(); chk3("br_jp", 32'h66, 32'h1C, 32'h20);
    pc_src = 0; jump = 0;

    // Enable low: redirect ignored, write accepted.
    enable = 0; pc_src = 1; branch_addr = 32'h4;
    wr_en = 1; wr_addr = 8'd3; wr_data = 32'hFFFFFFFF;
    cyc(); chk3("frozen", 32'h66, 32'h1C, 32'h20);
    pc_src = 0; wr_en = 0;

    // Redirect honoured during stall.
    enable = 1; stall = 1; jump = 1; jump_addr = 32'hC;
    cyc(); chk3("jp_stall", 32'h66, 32'h1C, 32'hC);
    stall = 0; jump = 0;

    // Fetch the halt word.
    cyc(); chk3("halt", 32'hFFFFFFFF, 32'h10, 32'hC);
    chk("halt.flag", {31'b0, halt}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk3("halted", 32'hFFFFFFFF, 32'h10, 32'hC);
      chk("halted.flag", {31'b0, halt}, 32'h1);
    end

    // Jump alone redirects but keeps halt.
    jump = 1; jump_addr = 32'h10;
    cyc(); chk3("h_jump", 32'hFFFFFFFF, 32'h10, 32'h10);
    chk("h_jump.flag", {31'b0, halt}, 32'h1);
    jump = 0;

    // Branch clears halt.
    pc_src = 1; branch_addr = 32'h4;
    cyc(); chk3("h_br", 32'hFFFFFFFF, 32'h10, 32'h4);
    chk("h_br.flag", {31'b0, halt}, 32'h0);
    pc_src = 0;
    cyc(); chk3("h_resume", 32'h11, 32'h8, 32'h8);

    // Wrap from word 255 to word 0.
    jump = 1; jump_addr = 32'h3FC;
    cyc(); chk3("wrap_jp", 32'h22, 32'hC, 32'h3FC);
    jump = 0;
    cyc(); chk3("wrap255", 32'hA5A50001, 32'h400, 32'h400);
    cyc(); chk3("wrap0", 32'h00, 32'h404, 32'h404);

    // Misaligned branch target is aligned on load.
    pc_src = 1; branch_addr = 32'h15; stall = 1;
    cyc(); chk3("align", 32'h00, 32'h404, 32'h14);
    pc_src = 0; stall = 0;

    // Mid-run reset keeps memory.
    reset = 1;
    cyc(); chk3("rst2", 32'h0, 32'h0, 32'h0);
    chk("rst2.halt", {31'b0, halt}, 32'h0);
    reset = 0;
    cyc(); chk3("rst2_f", 32'h00, 32'h4, 32'h4);

    // Flush beats stall.
    stall = 1; flush = 1;
    cyc(); chk3("fl_st", 32'h0, 32'h8, 32'h4);
    stall = 0; flush = 0;
    cyc(); chk3("fl_st2", 32'h11, 32'h8, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
